// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset vector default and the
// opcode/funct encodings that the fetch unit and the controller both need.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [5:0] FUNCT_JR = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory request/response bus between the fetch unit and imem.
interface ifu_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection: jr, jump, taken branch, or sequential.
// Kept free of state so a pipelined front end can reuse it unchanged.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] pc4
);

    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic        unused_opcode;

    // The opcode field plays no part in target arithmetic.
    assign unused_opcode = ^instruction[31:26];

    // Candidate targets; all sums wrap silently modulo 2^32.
    always_comb begin
        pc4     = pc + 32'd4;
        btarget = pc4 + (sign_ext16(instruction[15:0]) << 2);
        jtarget = {pc4[31:28], instruction[25:0], 2'b00};
    end

    // Priority: jr over jump over taken branch over fall-through.
    always_comb begin
        npc = pc4;
        if (jr) begin
            npc = jr_target;
        end else if (jump) begin
            npc = jtarget;
        end else if (branch && zero) begin
            npc = btarget;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over
// the imem handshake, holds it for the controller until commit, then steps
// the PC. A misaligned target parks the unit in FAULT until reset.
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ifu_fetch_if.master        imem,
    output logic [31:0]        instruction,
    output logic               inst_valid,
    input  logic               commit,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    output logic [31:0]        pc,
    output logic [31:0]        link_addr,
    output logic               fault
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instruction_reg, instruction_next;
    logic [31:0]  jr_target_use;
    logic [31:0]  npc;
    logic [31:0]  pc4;
    logic         misaligned;

    // Without alignment checking the register target is simply truncated to
    // a word boundary, so every candidate target is aligned.
    generate
        if (ALIGN_CHECK) begin : g_jr_checked
            assign jr_target_use = jr_target;
        end else begin : g_jr_forced
            logic unused_jr_low;
            assign unused_jr_low = ^jr_target[1:0];
            assign jr_target_use = {jr_target[31:2], 2'b00};
        end
    endgenerate

    npc_calc u_npc_calc (
        .pc          (pc_reg),
        .instruction (instruction_reg),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .jr          (jr),
        .jr_target   (jr_target_use),
        .npc         (npc),
        .pc4         (pc4)
    );

    assign misaligned = ALIGN_CHECK && (npc[1:0] != 2'b00);

    // State, PC and instruction latch; reset abandons any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            instruction_reg <= 32'h0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instruction_reg <= instruction_next;
        end
    end

    // Next-state logic: latch on ready in FETCH, step PC on commit in ISSUE.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instruction_next = instruction_reg;
        case (state_reg)
            FETCH: begin
                if (imem.ready) begin
                    instruction_next = imem.rdata;
                    state_next       = ISSUE;
                end
            end
            ISSUE: begin
                if (commit) begin
                    if (misaligned) begin
                        state_next = FAULT;
                    end else begin
                        pc_next    = {npc[31:2], 2'b00};
                        state_next = FETCH;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    // Outputs decoded from state; the request is gated by reset so it drops
    // the moment rst_n falls.
    always_comb begin
        imem.req    = rst_n && (state_reg == FETCH);
        imem.addr   = pc_reg;
        instruction = instruction_reg;
        inst_valid  = (state_reg == ISSUE);
        fault       = (state_reg == FAULT);
        pc          = pc_reg;
        link_addr   = pc4;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a table of fetch/commit transactions chained
// through the PC, followed by hand-written fault and reset sequences.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        commit;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        fault;

    int checks = 0;
    int errors = 0;

    ifu_fetch_if imem_bus ();

    ifu_fetch #(
        .RESET_PC    (32'h0000_3000),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .commit      (commit),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .jr          (jr),
        .jr_target   (jr_target),
        .pc          (pc),
        .link_addr   (link_addr),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] instr;
        logic        br;
        logic        z;
        logic        j;
        logic        jrv;
        logic [31:0] jrt;
        int          delay;
        int          hold;
        logic [31:0] exp_link;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        commit    = 1'b0;
        branch    = 1'b0;
        zero      = 1'b0;
        jump      = 1'b0;
        jr        = 1'b0;
        jr_target = 32'h0;
    endtask

    logic [31:0] exp_pc;

    initial begin
        //           instr         br    z     j     jr    jr_target     dly hold link          npc
        vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_3004, 32'h0000_3004};
        vecs[1]  = '{32'h0800_0C04, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5, 2, 32'h0000_3008, 32'h0000_3010};
        vecs[2]  = '{32'h1000_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_3014, 32'h0000_3004};
        vecs[3]  = '{32'h0800_0C04, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1, 0, 32'h0000_3008, 32'h0000_3010};
        vecs[4]  = '{32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_3014, 32'h0000_3014};
        vecs[5]  = '{32'h0C00_0C00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         0, 0, 32'h0000_3018, 32'h0000_3000};
        vecs[6]  = '{32'h0C00_0C10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         0, 0, 32'h0000_3004, 32'h0000_3040};
        vecs[7]  = '{32'h03E0_0008, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3008, 0, 0, 32'h0000_3044, 32'h0000_3008};
        vecs[8]  = '{32'h1109_0003, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         2, 0, 32'h0000_300C, 32'h0000_3018};
        vecs[9]  = '{32'h1000_FFF0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1, 32'h0000_301C, 32'h0000_301C};
        vecs[10] = '{32'h03E0_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 0, 0, 32'h0000_3020, 32'hFFFF_FFFC};
        vecs[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[12] = '{32'h0800_0C00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         0, 0, 32'h0000_0004, 32'h0000_3000};

        rst_n          = 1'b0;
        imem_bus.ready = 1'b0;
        imem_bus.rdata = 32'h0;
        clear_ctl();

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_req", {31'h0, imem_bus.req}, 32'h0);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of fetch/commit transactions, PC chained from one to the next.
        exp_pc = 32'h0000_3000;
        for (int i = 0; i < 13; i++) begin
            for (int d = 0; d < vecs[i].delay; d++) begin
                chk($sformatf("v%0d_wait_req", i), {31'h0, imem_bus.req}, 32'h1);
                chk($sformatf("v%0d_wait_valid", i), {31'h0, inst_valid}, 32'h0);
                chk($sformatf("v%0d_wait_pc", i), pc, exp_pc);
                imem_bus.ready = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("v%0d_req", i), {31'h0, imem_bus.req}, 32'h1);
            chk($sformatf("v%0d_addr", i), imem_bus.addr, exp_pc);
            imem_bus.ready = 1'b1;
            imem_bus.rdata = vecs[i].instr;
            @(negedge clk);
            imem_bus.ready = 1'b0;
            imem_bus.rdata = 32'h0;
            chk($sformatf("v%0d_valid", i), {31'h0, inst_valid}, 32'h1);
            chk($sformatf("v%0d_instr", i), instruction, vecs[i].instr);
            chk($sformatf("v%0d_issue_req", i), {31'h0, imem_bus.req}, 32'h0);
            chk($sformatf("v%0d_link", i), link_addr, vecs[i].exp_link);
            for (int h = 0; h < vecs[i].hold; h++) begin
                imem_bus.ready = 1'b1;
                imem_bus.rdata = 32'hDEAD_BEEF;
                @(negedge clk);
                imem_bus.ready = 1'b0;
                chk($sformatf("v%0d_hold_instr", i), instruction, vecs[i].instr);
                chk($sformatf("v%0d_hold_pc", i), pc, exp_pc);
            end
            branch    = vecs[i].br;
            zero      = vecs[i].z;
            jump      = vecs[i].j;
            jr        = vecs[i].jrv;
            jr_target = vecs[i].jrt;
            commit    = 1'b1;
            @(negedge clk);
            clear_ctl();
            chk($sformatf("v%0d_npc", i), pc, vecs[i].exp_npc);
            chk($sformatf("v%0d_post_valid", i), {31'h0, inst_valid}, 32'h0);
            chk($sformatf("v%0d_post_fault", i), {31'h0, fault}, 32'h0);
            $display("vec %0d: instr=%h npc=%h link=%h", i, vecs[i].instr, pc, vecs[i].exp_link);
            exp_pc = vecs[i].exp_npc;
        end

        // Misaligned jr target: enter FAULT with PC held.
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 32'h03E0_0008;
        @(negedge clk);
        imem_bus.ready = 1'b0;
        chk("flt_valid_before", {31'h0, inst_valid}, 32'h1);
        jr        = 1'b1;
        jr_target = 32'h0000_3006;
        commit    = 1'b1;
        @(negedge clk);
        clear_ctl();
        chk("flt_fault", {31'h0, fault}, 32'h1);
        chk("flt_req", {31'h0, imem_bus.req}, 32'h0);
        chk("flt_valid", {31'h0, inst_valid}, 32'h0);
        chk("flt_pc", pc, 32'h0000_3000);
        $display("fault entry: pc=%h fault=%0b", pc, fault);

        // Commits and ready pulses are ignored while faulted.
        for (int k = 0; k < 3; k++) begin
            jr             = 1'b1;
            jr_target      = 32'h0000_3008;
            commit         = 1'b1;
            imem_bus.ready = 1'b1;
            @(negedge clk);
            chk("flt_sticky", {31'h0, fault}, 32'h1);
            chk("flt_hold_pc", pc, 32'h0000_3000);
            chk("flt_hold_req", {31'h0, imem_bus.req}, 32'h0);
        end
        clear_ctl();
        imem_bus.ready = 1'b0;

        // Asynchronous reset clears the fault without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("frst_fault", {31'h0, fault}, 32'h0);
        chk("frst_pc", pc, 32'h0000_3000);
        chk("frst_req", {31'h0, imem_bus.req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("frst_refetch_req", {31'h0, imem_bus.req}, 32'h1);
        chk("frst_refetch_addr", imem_bus.addr, 32'h0000_3000);
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 32'h2008_0005;
        @(negedge clk);
        imem_bus.ready = 1'b0;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("frst_step_pc", pc, 32'h0000_3004);
        $display("post-fault reset: pc=%h", pc);

        // Reset asserted mid-FETCH while ready pulses: nothing is latched.
        chk("mid_req_before", {31'h0, imem_bus.req}, 32'h1);
        rst_n          = 1'b0;
        imem_bus.ready = 1'b1;
        imem_bus.rdata = 32'hCAFE_BABE;
        #1;
        chk("mid_req_drop", {31'h0, imem_bus.req}, 32'h0);
        chk("mid_pc", pc, 32'h0000_3000);
        @(negedge clk);
        chk("mid_instr", instruction, 32'h0);
        chk("mid_valid", {31'h0, inst_valid}, 32'h0);
        imem_bus.ready = 1'b0;
        rst_n          = 1'b1;
        @(negedge clk);
        chk("mid_after_valid", {31'h0, inst_valid}, 32'h0);
        chk("mid_after_instr", instruction, 32'h0);
        chk("mid_after_req", {31'h0, imem_bus.req}, 32'h1);
        $display("mid-fetch reset: pc=%h instr=%h", pc, instruction);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
